// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx serializer between NREQ byte-stream requesters. Whole
// messages are arbitrated round-robin, so one requester's bytes never
// interleave with another's. The grant is held from a message's first byte
// through the byte flagged last. Each byte goes through the uart_tx handshake:
// a one-cycle tx_dv, then wait for tx_active, then wait for tx_done, then an
// optional idle gap of GAP_CLKS cycles.
//
// Parameters:
//   NREQ       number of requesters (2..8)
//   GAP_CLKS   idle cycles after tx_done before the next byte is fetched
//   STALL_CLKS owner-stall limit in FETCH (STALL_TIMEOUT_EN builds only)
//
// Ports:
//   clk        system clock
//   reset_n    synchronous active-low reset
//   req_data   byte from requester i on bits [8i+7:8i]
//   req_valid  requester i has a byte
//   req_last   byte from requester i ends its message
//   req_ready  byte from requester i accepted this cycle
//   grant      one-hot current owner, 0 when idle
//   busy       grant held or byte in flight
//   tx_dv      uart_tx i_TX_DV
//   tx_byte    uart_tx i_TX_Byte
//   tx_active  uart_tx o_TX_Active
//   tx_done    uart_tx o_TX_Done
//   stall_err  one-cycle pulse when a stalled message is abandoned
//
// Optional feature (compile-time macro STALL_TIMEOUT_EN):
//   defined   - an owner that withholds req_valid in FETCH for STALL_CLKS
//               cycles loses the grant and its partial message is dropped.
//   undefined - FETCH waits indefinitely and stall_err is tied low.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ       = 2,
  parameter int GAP_CLKS   = 10,
  parameter int STALL_CLKS = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  output logic              stall_err
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    WAIT_ACT,
    WAIT_DONE,
    GAP
  } state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               last_q, last_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  // Owner's request lines
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;

  // Round-robin search result
  logic               arb_found;
  logic [PTR_W-1:0]   arb_idx;
  logic [PTR_W-1:0]   arb_cand;

  logic [PTR_W-1:0]   next_ptr;
  logic               byte_end;
  logic               stall_hit;

`ifdef STALL_TIMEOUT_EN
  localparam int STALL_W = (STALL_CLKS > 0) ? $clog2(STALL_CLKS + 1) : 1;
  logic [STALL_W-1:0] stall_q, stall_d;
`endif

  // ---------------------------------------------------------------------------
  // Owner request mux
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == PTR_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid requester at or after ptr, wrapping mod NREQ
  // ---------------------------------------------------------------------------
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      arb_cand = PTR_W'((32'(ptr_q) + k) % NREQ);
      if (!arb_found && req_valid[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  // Pointer moves past the current owner when its message ends or is dropped
  assign next_ptr = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + PTR_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tx_byte_d = tx_byte_q;
    last_d    = last_q;
    gap_d     = gap_q;
    req_ready = '0;
    tx_dv     = 1'b0;
    byte_end  = 1'b0;
    stall_hit = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_d = NREQ'(1) << arb_idx;
          owner_d = arb_idx;
          state_d = FETCH;
        end
      end

      FETCH: begin
        req_ready = grant_q & req_valid;
        if (sel_valid) begin
          tx_byte_d = sel_data;
          last_d    = sel_last;
          state_d   = SEND;
        end
`ifdef STALL_TIMEOUT_EN
        else if (stall_q == STALL_W'(STALL_CLKS - 1)) begin
          stall_hit = 1'b1;
          grant_d   = '0;
          ptr_d     = next_ptr;
          state_d   = IDLE;
        end
`endif
      end

      SEND: begin
        tx_dv   = 1'b1;
        state_d = WAIT_ACT;
      end

      WAIT_ACT: begin
        if (tx_active) begin
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (tx_done) begin
          // With no gap configured the GAP state is skipped entirely.
          if (GAP_CLKS == 0) begin
            byte_end = 1'b1;
          end else begin
            gap_d   = GAP_W'(GAP_CLKS);
            state_d = GAP;
          end
        end
      end

      GAP: begin
        // Counter enters at GAP_CLKS and the state lasts exactly GAP_CLKS cycles.
        if (gap_q <= GAP_W'(1)) begin
          gap_d    = '0;
          byte_end = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (byte_end) begin
      if (last_q) begin
        grant_d = '0;
        ptr_d   = next_ptr;
        state_d = IDLE;
      end else begin
        state_d = FETCH;
      end
    end
  end

`ifdef STALL_TIMEOUT_EN
  // Counts consecutive FETCH cycles with the owner's valid low; any accept or
  // leaving FETCH clears it.
  always_comb begin
    stall_d = '0;
    if (state_q == FETCH && !sel_valid && !stall_hit) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_err = stall_hit;
`else
  // STALL_CLKS only matters for the timeout build; fold it into a sink.
  logic unused_stall_clks;
  assign unused_stall_clks = |32'(STALL_CLKS) | stall_hit;
  assign stall_err         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      tx_byte_q <= '0;
      last_q    <= 1'b0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tx_byte_q <= tx_byte_d;
      last_q    <= last_d;
      gap_q     <= gap_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign tx_byte = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NREQ  = 2;
  localparam int GAP   = 10;
  localparam int STALL = 100;
  localparam int FRAME = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        busy;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic        stall_err;

  uart_tx_arbiter #(
    .NREQ      (NREQ),
    .GAP_CLKS  (GAP),
    .STALL_CLKS(STALL)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_data (req_data),
    .req_valid(req_valid),
    .req_last (req_last),
    .req_ready(req_ready),
    .grant    (grant),
    .busy     (busy),
    .tx_dv    (tx_dv),
    .tx_byte  (tx_byte),
    .tx_active(tx_active),
    .tx_done  (tx_done),
    .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] g;
    logic [7:0] b;
  } exp_t;

  typedef struct packed {
    logic [1:0]  g;
    logic [7:0]  b;
    logic [31:0] cyc;
  } obs_t;

  exp_t        exp_q[$];
  obs_t        obs_q[$];
  int unsigned done_q[$];
  int unsigned err_q[$];
  logic [1:0]  post_err_grant_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: tx_active for FRAME cycles after tx_dv, then a tx_done pulse
  int unsigned m_cnt = 0;
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (m_cnt != 0) begin
      if (m_cnt == 1) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
      end
      m_cnt <= m_cnt - 1;
    end else if (tx_dv) begin
      tx_active <= 1'b1;
      m_cnt     <= FRAME;
    end
  end

  // Output monitor, sampled on the falling edge
  logic prev_err = 1'b0;
  always @(negedge clk) begin
    obs_t o;
    if (prev_err) post_err_grant_q.push_back(grant);
    prev_err <= stall_err;
    if (tx_dv) begin
      o.g   = grant;
      o.b   = tx_byte;
      o.cyc = cyc;
      obs_q.push_back(o);
    end
    if (tx_done) done_q.push_back(cyc);
    if (stall_err) err_q.push_back(cyc);
  end

  function automatic exp_t mk(input logic [1:0] g, input logic [7:0] b);
    exp_t e;
    e.g = g;
    e.b = b;
    return e;
  endfunction

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    done_q.delete();
    err_q.delete();
    post_err_grant_q.delete();
  endtask

  // Requester driver: presents n bytes (byte k = bytes[8k+7:8k], last = lasts[k]),
  // optionally dropping valid for stall_cyc cycles before byte stall_after.
  task automatic send_msg(input int unsigned r, input logic [63:0] bytes,
                          input int unsigned n, input logic [7:0] lasts,
                          input int unsigned stall_after, input int unsigned stall_cyc,
                          output bit ok);
    logic [63:0] sb;
    logic [7:0]  sl;
    bit          acc;
    int unsigned w;
    ok = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == stall_after && stall_cyc > 0) begin
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
        repeat (stall_cyc) @(negedge clk);
      end
      sb = bytes >> (8 * k);
      sl = lasts >> k;
      req_data[8*r +: 8] = sb[7:0];
      req_last[r]        = sl[0];
      req_valid[r]       = 1'b1;
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 2000) begin
        #1;
        if (req_ready[r]) acc = 1'b1;
        else begin
          @(negedge clk);
          w++;
        end
      end
      if (!acc) begin
        ok = 1'b0;
        req_valid[r] = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
    req_last[r]  = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 1000; w++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit   ok;
    bit   act;
    exp_t e;
    obs_t o;
    clear_queues();
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if ({grant, busy, tx_dv, tx_byte, req_ready, stall_err} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_por: got %h expected 0", {grant, busy, tx_dv, tx_byte, req_ready, stall_err});
    end
    reset_n = 1'b1;

    // One-byte message, then reset while the DUT sits in WAIT_DONE
    exp_q.push_back(mk(2'b01, 8'hA5));
    send_msg(0, 64'hA5, 1, 8'h01, 0, 0, ok);
    act = 1'b0;
    for (int w = 0; w < 100 && !act; w++) begin
      @(negedge clk);
      act = tx_active;
    end
    n_tests++;
    if (!(ok && act)) begin
      n_fail++;
      $display("FAIL reset_setup: got ok=%0b active=%0b expected 1 1", ok, act);
    end
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({grant, busy, tx_dv, tx_byte, req_ready, stall_err} !== 15'h0) begin
        n_fail++;
        $display("FAIL reset_mid%0d: got %h expected 0", i, {grant, busy, tx_dv, tx_byte, req_ready, stall_err});
      end
    end
    reset_n = 1'b1;
    repeat (40) @(negedge clk);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL reset_byte: got none expected g=%b b=%h", e.g, e.b);
      end else begin
        o = obs_q.pop_front();
        if ({o.g, o.b} !== {e.g, e.b}) begin
          n_fail++;
          $display("FAIL reset_byte: got g=%b b=%h expected g=%b b=%h", o.g, o.b, e.g, e.b);
        end
      end
    end
    n_tests++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_quiet: got extra=%0d busy=%b expected 0 0", obs_q.size(), busy);
    end
  endtask

  task automatic test_contention();
    bit   ok0, ok1, okw;
    exp_t e;
    obs_t o;
    clear_queues();
    exp_q.push_back(mk(2'b01, 8'h01));
    exp_q.push_back(mk(2'b01, 8'h02));
    exp_q.push_back(mk(2'b01, 8'h03));
    exp_q.push_back(mk(2'b10, 8'h81));
    exp_q.push_back(mk(2'b10, 8'h82));
    exp_q.push_back(mk(2'b10, 8'h83));
    fork
      send_msg(0, 64'h030201, 3, 8'h04, 0, 0, ok0);
      send_msg(1, 64'h838281, 3, 8'h04, 0, 0, ok1);
    join
    wait_idle(okw);
    n_tests++;
    if (!(ok0 && ok1 && okw)) begin
      n_fail++;
      $display("FAIL contention_progress: got %0b%0b%0b expected 111", ok0, ok1, okw);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL contention_byte: got none expected g=%b b=%h", e.g, e.b);
      end else begin
        o = obs_q.pop_front();
        if ({o.g, o.b} !== {e.g, e.b}) begin
          n_fail++;
          $display("FAIL contention_byte: got g=%b b=%h expected g=%b b=%h", o.g, o.b, e.g, e.b);
        end
      end
    end
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL contention_extra: got %0d expected 0", obs_q.size());
    end
  endtask

  task automatic test_single_msg();
    bit          ok0, okw;
    int unsigned gap_seen;
    exp_t        e;
    obs_t        o;
    clear_queues();
    exp_q.push_back(mk(2'b01, 8'h48));
    exp_q.push_back(mk(2'b01, 8'h69));
    send_msg(0, 64'h6948, 2, 8'h02, 0, 0, ok0);
    wait_idle(okw);
    n_tests++;
    if (!(ok0 && okw)) begin
      n_fail++;
      $display("FAIL single_progress: got %0b%0b expected 11", ok0, okw);
    end
    // done cycle, GAP cycles, one FETCH cycle, then SEND
    gap_seen = (obs_q.size() >= 2 && done_q.size() >= 1) ? obs_q[1].cyc - done_q[0] : 0;
    n_tests++;
    if (gap_seen !== GAP + 2) begin
      n_fail++;
      $display("FAIL single_spacing: got %0d expected %0d", gap_seen, GAP + 2);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL single_byte: got none expected g=%b b=%h", e.g, e.b);
      end else begin
        o = obs_q.pop_front();
        if ({o.g, o.b} !== {e.g, e.b}) begin
          n_fail++;
          $display("FAIL single_byte: got g=%b b=%h expected g=%b b=%h", o.g, o.b, e.g, e.b);
        end
      end
    end
    n_tests++;
    if (obs_q.size() != 0 || grant !== 2'b00) begin
      n_fail++;
      $display("FAIL single_end: got extra=%0d grant=%b expected 0 00", obs_q.size(), grant);
    end
  endtask

  task automatic test_fairness();
    bit   ok0, ok1, okw;
    exp_t e;
    obs_t o;
    clear_queues();
    exp_q.push_back(mk(2'b01, 8'hA0));
    exp_q.push_back(mk(2'b01, 8'hA1));
    exp_q.push_back(mk(2'b10, 8'hC0));
    exp_q.push_back(mk(2'b01, 8'hB0));
    exp_q.push_back(mk(2'b01, 8'hB1));
    fork
      send_msg(0, 64'hB1B0A1A0, 4, 8'h0A, 0, 0, ok0);
      begin
        repeat (5) @(negedge clk);
        send_msg(1, 64'hC0, 1, 8'h01, 0, 0, ok1);
      end
    join
    wait_idle(okw);
    n_tests++;
    if (!(ok0 && ok1 && okw)) begin
      n_fail++;
      $display("FAIL fair_progress: got %0b%0b%0b expected 111", ok0, ok1, okw);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL fair_byte: got none expected g=%b b=%h", e.g, e.b);
      end else begin
        o = obs_q.pop_front();
        if ({o.g, o.b} !== {e.g, e.b}) begin
          n_fail++;
          $display("FAIL fair_byte: got g=%b b=%h expected g=%b b=%h", o.g, o.b, e.g, e.b);
        end
      end
    end
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL fair_extra: got %0d expected 0", obs_q.size());
    end
  endtask

  task automatic test_owner_stall();
    bit          ok0, ok1, okw, seen;
    int unsigned bad, sz;
    exp_t        e;
    obs_t        o;
    clear_queues();
    exp_q.push_back(mk(2'b10, 8'h11));
    exp_q.push_back(mk(2'b10, 8'h12));
    exp_q.push_back(mk(2'b10, 8'h13));
    exp_q.push_back(mk(2'b01, 8'h77));
    bad = 0;
    sz  = 0;
    fork
      send_msg(1, 64'h131211, 3, 8'h04, 1, 50, ok1);
      begin
        repeat (10) @(negedge clk);
        send_msg(0, 64'h77, 1, 8'h01, 0, 0, ok0);
      end
      begin
        seen = 1'b0;
        for (int w = 0; w < 100 && !seen; w++) begin
          @(negedge clk);
          seen = (obs_q.size() >= 1);
        end
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (grant !== 2'b10 || req_ready[0] !== 1'b0 || stall_err !== 1'b0) bad++;
        end
        sz = obs_q.size();
      end
    join
    wait_idle(okw);
    n_tests++;
    if (!(ok0 && ok1 && okw)) begin
      n_fail++;
      $display("FAIL stall_progress: got %0b%0b%0b expected 111", ok0, ok1, okw);
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
    end
    n_tests++;
    if (sz !== 1) begin
      n_fail++;
      $display("FAIL stall_no_dv: got %0d bytes expected 1", sz);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL stall_byte: got none expected g=%b b=%h", e.g, e.b);
      end else begin
        o = obs_q.pop_front();
        if ({o.g, o.b} !== {e.g, e.b}) begin
          n_fail++;
          $display("FAIL stall_byte: got g=%b b=%h expected g=%b b=%h", o.g, o.b, e.g, e.b);
        end
      end
    end
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_extra: got %0d expected 0", obs_q.size());
    end
  endtask

  task automatic test_stall_timeout();
    bit          ok0, ok1, okw;
    int unsigned dt;
    exp_t        e;
    obs_t        o;
    clear_queues();
`ifdef STALL_TIMEOUT_EN
    exp_q.push_back(mk(2'b10, 8'h31));
    exp_q.push_back(mk(2'b01, 8'h40));
    exp_q.push_back(mk(2'b10, 8'h32));
`else
    exp_q.push_back(mk(2'b10, 8'h31));
    exp_q.push_back(mk(2'b10, 8'h32));
    exp_q.push_back(mk(2'b01, 8'h40));
`endif
    fork
      send_msg(1, 64'h3231, 2, 8'h02, 1, 200, ok1);
      begin
        repeat (10) @(negedge clk);
        send_msg(0, 64'h40, 1, 8'h01, 0, 0, ok0);
      end
    join
    wait_idle(okw);
    n_tests++;
    if (!(ok0 && ok1 && okw)) begin
      n_fail++;
      $display("FAIL timeout_progress: got %0b%0b%0b expected 111", ok0, ok1, okw);
    end
`ifdef STALL_TIMEOUT_EN
    n_tests++;
    if (err_q.size() !== 1) begin
      n_fail++;
      $display("FAIL timeout_pulses: got %0d expected 1", err_q.size());
    end
    // GAP cycles after done, then the STALL-th stalled FETCH cycle
    dt = (err_q.size() >= 1 && done_q.size() >= 1) ? err_q[0] - done_q[0] : 0;
    n_tests++;
    if (dt !== GAP + STALL) begin
      n_fail++;
      $display("FAIL timeout_cycle: got %0d expected %0d", dt, GAP + STALL);
    end
    n_tests++;
    if (post_err_grant_q.size() < 1 || post_err_grant_q[0] !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_grant: got %0d entries expected grant 00", post_err_grant_q.size());
    end
`else
    n_tests++;
    if (err_q.size() !== 0) begin
      n_fail++;
      $display("FAIL timeout_pulses: got %0d expected 0", err_q.size());
    end
    dt = 0;
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL timeout_byte: got none expected g=%b b=%h", e.g, e.b);
      end else begin
        o = obs_q.pop_front();
        if ({o.g, o.b} !== {e.g, e.b}) begin
          n_fail++;
          $display("FAIL timeout_byte: got g=%b b=%h expected g=%b b=%h", o.g, o.b, e.g, e.b);
        end
      end
    end
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_extra: got %0d expected 0", obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_msg();
    test_fairness();
    test_owner_stall();
    test_stall_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
